stopwatch_ctrl: RTL and testbench

Sequencing controller for the two-digit BCD stopwatch counter. It turns debounced start/stop and lap/reset button levels into a prescaled count-enable pulse and a clear pulse for the counter. It also provides a lap-hold display path that freezes the shown digits while counting continues. It sits between the button debouncers, the counter, and the seven-segment driver.

---
 rtl/stopwatch_ctrl.sv | 106 ++++++++++
 tb/tb_stopwatch_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: button press decode, tick prescaler, counter clear and lap-hold display.
// Outputs are registered; presses take effect on the edge they are sampled.
module stopwatch_ctrl #(
  parameter int digit_regs = 4,
  parameter int TICK_DIV   = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  btn_ss,
  input  logic                  btn_lr,
  input  logic [digit_regs-1:0] tens,
  input  logic [digit_regs-1:0] ones,
  output logic                  cnt_en,
  output logic                  cnt_clr,
  output logic [digit_regs-1:0] disp_tens,
  output logic [digit_regs-1:0] disp_ones,
  output logic [1:0]            state
);

  localparam int DW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    LAP   = 2'd2,
    PAUSE = 2'd3
  } state_t;

  state_t                st;
  logic [DW-1:0]         div;
  logic                  ss_prev;
  logic                  lr_prev;
  logic [digit_regs-1:0] hold_tens;
  logic [digit_regs-1:0] hold_ones;

  logic ss_p;
  logic lr_p;
  logic wrap;

  // lr is only honoured when ss is not pressed in the same cycle
  assign ss_p  = btn_ss & ~ss_prev;
  assign lr_p  = btn_lr & ~lr_prev & ~ss_p;
  assign wrap  = (div == DIV_MAX);
  assign state = st;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st        <= IDLE;
      div       <= '0;
      ss_prev   <= 1'b1;
      lr_prev   <= 1'b1;
      cnt_en    <= 1'b0;
      cnt_clr   <= 1'b0;
      disp_tens <= '0;
      disp_ones <= '0;
      hold_tens <= '0;
      hold_ones <= '0;
    end else begin
      ss_prev   <= btn_ss;
      lr_prev   <= btn_lr;
      cnt_en    <= 1'b0;
      cnt_clr   <= 1'b0;
      disp_tens <= tens;
      disp_ones <= ones;
      case (st)
        IDLE: begin
          div <= '0;
          if (ss_p) st <= RUN;
        end
        RUN, LAP: begin
          div <= wrap ? '0 : div + 1'b1;
          // a pause press swallows the tick that wraps on the same edge
          if (ss_p) begin
            st <= PAUSE;
          end else begin
            cnt_en <= wrap;
            if (lr_p) begin
              if (st == RUN) begin
                st        <= LAP;
                hold_tens <= tens;
                hold_ones <= ones;
              end else begin
                st <= RUN;
              end
            end else if (st == LAP) begin
              disp_tens <= hold_tens;
              disp_ones <= hold_ones;
            end
          end
        end
        PAUSE: begin
          if (ss_p) begin
            st <= RUN;
          end else if (lr_p) begin
            st      <= IDLE;
            div     <= '0;
            cnt_clr <= 1'b1;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with TICK_DIV=4.
module tb_stopwatch_ctrl;

  logic       clk;
  logic       rst;
  logic       btn_ss;
  logic       btn_lr;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       cnt_en;
  logic       cnt_clr;
  logic [3:0] disp_tens;
  logic [3:0] disp_ones;
  logic [1:0] state;

  int vectors;
  int errors;

  stopwatch_ctrl #(.digit_regs(4), .TICK_DIV(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_ss    (btn_ss),
    .btn_lr    (btn_lr),
    .tens      (tens),
    .ones      (ones),
    .cnt_en    (cnt_en),
    .cnt_clr   (cnt_clr),
    .disp_tens (disp_tens),
    .disp_ones (disp_ones),
    .state     (state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance n rising edges, then settle 1 time unit so outputs can be sampled
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    rst     = 1'b0;
    btn_ss  = 1'b1;
    btn_lr  = 1'b0;
    tens    = 4'd5;
    ones    = 4'd3;

    // reset values while held in reset with ss held high
    tick(2);
    chk("rst_state", state, 0);
    chk("rst_cnt_en", cnt_en, 0);
    chk("rst_cnt_clr", cnt_clr, 0);
    chk("rst_disp", {disp_tens, disp_ones}, 8'h00);

    // release reset with ss still held: no press
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("held_state", state, 0);
      chk("held_cnt_en", cnt_en, 0);
    end
    chk("idle_disp_live", {disp_tens, disp_ones}, 8'h53);

    // release then press ss: RUN, cnt_en every 4 cycles
    btn_ss = 1'b0;
    tick(1);
    btn_ss = 1'b1;
    tick(1);
    btn_ss = 1'b0;
    chk("start_state", state, 1);
    for (int i = 1; i <= 8; i++) begin
      tick(1);
      chk("run_cnt_en", cnt_en, (i % 4 == 0) ? 1 : 0);
    end

    // pause 2 cycles after a cnt_en, partial tick kept
    tick(1);
    btn_ss = 1'b1;
    tick(1);
    btn_ss = 1'b0;
    chk("pause_state", state, 3);
    chk("pause_cnt_en", cnt_en, 0);
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk("paused_cnt_en", cnt_en, 0);
    end
    btn_ss = 1'b1;
    tick(1);
    btn_ss = 1'b0;
    chk("resume_state", state, 1);
    chk("resume_cnt_en0", cnt_en, 0);
    tick(1);
    chk("resume_cnt_en1", cnt_en, 0);
    tick(1);
    chk("resume_cnt_en2", cnt_en, 1);

    // lap hold at 1/7 while the counter moves on to 2/3
    tens = 4'd1;
    ones = 4'd7;
    tick(1);
    btn_lr = 1'b1;
    tick(1);
    btn_lr = 1'b0;
    chk("lap_state", state, 2);
    chk("lap_disp", {disp_tens, disp_ones}, 8'h17);
    tens = 4'd2;
    ones = 4'd3;
    for (int i = 1; i <= 6; i++) begin
      tick(1);
      chk("lap_cnt_en", cnt_en, (i == 2 || i == 6) ? 1 : 0);
      chk("lap_disp_hold", {disp_tens, disp_ones}, 8'h17);
    end
    btn_lr = 1'b1;
    tick(1);
    btn_lr = 1'b0;
    chk("unlap_state", state, 1);
    chk("unlap_disp", {disp_tens, disp_ones}, 8'h23);
    tens = 4'd4;
    ones = 4'd8;
    tick(1);
    chk("live_disp", {disp_tens, disp_ones}, 8'h48);

    // pause then clear
    btn_ss = 1'b1;
    tick(1);
    btn_ss = 1'b0;
    chk("pause2_state", state, 3);
    tick(1);
    btn_lr = 1'b1;
    tick(1);
    btn_lr = 1'b0;
    chk("clr_state", state, 0);
    chk("clr_pulse", cnt_clr, 1);
    chk("clr_cnt_en", cnt_en, 0);
    tick(1);
    chk("clr_pulse_end", cnt_clr, 0);
    btn_lr = 1'b1;
    tick(1);
    btn_lr = 1'b0;
    chk("idle_lr_state", state, 0);
    chk("idle_lr_clr", cnt_clr, 0);
    tick(1);

    // restart: a cleared prescaler gives the full 4-cycle first tick
    btn_ss = 1'b1;
    tick(1);
    btn_ss = 1'b0;
    chk("restart_state", state, 1);
    for (int i = 1; i <= 4; i++) begin
      tick(1);
      chk("restart_cnt_en", cnt_en, (i == 4) ? 1 : 0);
    end

    // simultaneous presses in RUN: ss wins
    tens   = 4'd6;
    ones   = 4'd6;
    btn_ss = 1'b1;
    btn_lr = 1'b1;
    tick(1);
    btn_ss = 1'b0;
    btn_lr = 1'b0;
    chk("both_run_state", state, 3);
    chk("both_run_cnt_en", cnt_en, 0);
    tens = 4'd7;
    ones = 4'd1;
    tick(1);
    chk("both_run_disp", {disp_tens, disp_ones}, 8'h71);

    // simultaneous presses in PAUSE: ss wins, no clear
    btn_ss = 1'b1;
    btn_lr = 1'b1;
    tick(1);
    btn_ss = 1'b0;
    btn_lr = 1'b0;
    chk("both_pause_state", state, 1);
    chk("both_pause_clr", cnt_clr, 0);
    tick(1);
    chk("both_pause_clr2", cnt_clr, 0);

    // asynchronous reset in LAP, mid-cycle
    btn_lr = 1'b1;
    tick(1);
    btn_lr = 1'b0;
    chk("lap2_state", state, 2);
    chk("lap2_disp", {disp_tens, disp_ones}, 8'h71);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_state", state, 0);
    chk("arst_cnt_en", cnt_en, 0);
    chk("arst_cnt_clr", cnt_clr, 0);
    chk("arst_disp", {disp_tens, disp_ones}, 8'h00);
    #3;
    rst = 1'b1;
    tick(1);
    chk("post_arst_state", state, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
